// File: rtl/data_sram_ctrl_pkg.sv
// Shared types and defaults for the data-side SRAM controller: write FSM
// state encodings, the LED register address and the write-enable pulse width.
package data_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    DSC_IDLE  = 3'd0,
    DSC_SETUP = 3'd1,
    DSC_PULSE = 3'd2,
    DSC_HOLD  = 3'd3,
    DSC_DONE  = 3'd4
  } dsc_state_e;

  localparam logic [31:0] DSC_LED_ADDR = 32'h1FFF_FFFC;
  localparam int unsigned DSC_WE_PULSE = 2;

endpackage

// File: rtl/data_sram_ctrl_if.sv
// CPU-side ram_* port of the data SRAM controller.
// Handshake: ram_ce_i is the request; it is accepted on a rising edge where
// stallreq_o is low, and the CPU holds every request field stable until then.
interface data_sram_ctrl_if;

  logic        ram_ce_i;
  logic        ram_we_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stallreq_o;

  modport master (
    output ram_ce_i, ram_we_i, ram_addr_i, ram_data_i,
    input  ram_data_o, stallreq_o
  );

  modport slave (
    input  ram_ce_i, ram_we_i, ram_addr_i, ram_data_i,
    output ram_data_o, stallreq_o
  );

endinterface

// File: rtl/data_sram_ctrl.sv
// Data-side controller for an asynchronous 32-bit SRAM: combinational reads,
// timed SETUP/PULSE/HOLD writes that stall the pipeline, plus one LED register.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned WE_PULSE = DSC_WE_PULSE,
  parameter logic [31:0] LED_ADDR = DSC_LED_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  data_sram_ctrl_if.slave   ram,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [15:0]       led_o,
  output dsc_state_e        state_o
);

  localparam int unsigned CNT_W = $clog2(WE_PULSE + 1);

  dsc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       led_q, led_d;

  logic hit, sram_req;
  logic unused_addr_bits;

  assign hit      = ram.ram_ce_i & (ram.ram_addr_i[31:2] == LED_ADDR[31:2]);
  assign sram_req = ram.ram_ce_i & ~hit;
  assign unused_addr_bits = ^ram.ram_addr_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DSC_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    data_d         = data_q;
    led_d          = led_q;
    sram_addr_o    = addr_q;
    sram_dq_o      = data_q;
    sram_dq_oe_o   = 1'b0;
    sram_ce_n_o    = 1'b1;
    sram_oe_n_o    = 1'b1;
    sram_we_n_o    = 1'b1;
    ram.ram_data_o = '0;
    ram.stallreq_o = 1'b0;

    unique case (state_q)
      DSC_IDLE: begin
        // The LED hit wins over the SRAM decode, so its address never reaches SRAM.
        if (hit && ram.ram_we_i) begin
          led_d = ram.ram_data_i[15:0];
        end else if (hit) begin
          ram.ram_data_o = {16'b0, led_q};
        end else if (sram_req && !ram.ram_we_i) begin
          sram_addr_o    = ram.ram_addr_i[ADDR_W+1:2];
          sram_ce_n_o    = 1'b0;
          sram_oe_n_o    = 1'b0;
          ram.ram_data_o = sram_dq_i;
        end else if (sram_req) begin
          ram.stallreq_o = 1'b1;
          addr_d         = ram.ram_addr_i[ADDR_W+1:2];
          data_d         = ram.ram_data_i;
          state_d        = DSC_SETUP;
        end
      end
      DSC_SETUP: begin
        sram_ce_n_o    = 1'b0;
        sram_dq_oe_o   = 1'b1;
        ram.stallreq_o = 1'b1;
        cnt_d          = CNT_W'(1);
        state_d        = DSC_PULSE;
      end
      DSC_PULSE: begin
        sram_ce_n_o    = 1'b0;
        sram_dq_oe_o   = 1'b1;
        sram_we_n_o    = 1'b0;
        ram.stallreq_o = 1'b1;
        if (cnt_q == CNT_W'(WE_PULSE)) begin
          state_d = DSC_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DSC_HOLD: begin
        sram_ce_n_o    = 1'b0;
        sram_dq_oe_o   = 1'b1;
        ram.stallreq_o = 1'b1;
        state_d        = DSC_DONE;
      end
      DSC_DONE: begin
        // The CPU still presents the finished write here; it must not restart.
        state_d = DSC_IDLE;
      end
      default: state_d = DSC_IDLE;
    endcase
  end

  assign led_o   = led_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: reset, reads, aliasing, LED access,
// timed writes, reset abort mid-pulse and back-to-back writes.
module tb_data_sram_ctrl;
  import data_sram_ctrl_pkg::*;

  localparam int ADDR_W = 20;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [31:0]       sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [15:0]       led;
  dsc_state_e        state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [51:0] exp_q[$];

  data_sram_ctrl_if ram_bus ();

  data_sram_ctrl #(
    .ADDR_W  (ADDR_W),
    .WE_PULSE(2),
    .LED_ADDR(32'h1FFF_FFFC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ram         (ram_bus),
    .sram_addr_o (sram_addr),
    .sram_dq_o   (sram_dq_o),
    .sram_dq_oe_o(sram_dq_oe),
    .sram_dq_i   (sram_dq_i),
    .sram_ce_n_o (sram_ce_n),
    .sram_oe_n_o (sram_oe_n),
    .sram_we_n_o (sram_we_n),
    .led_o       (led),
    .state_o     (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    @(posedge clk); #1;
    ram_bus.ram_ce_i   = 1'b0;
    ram_bus.ram_we_i   = 1'b0;
    ram_bus.ram_addr_i = '0;
    ram_bus.ram_data_i = '0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ram_bus.ram_ce_i   = 1'b1;
    ram_bus.ram_we_i   = we;
    ram_bus.ram_addr_i = a;
    ram_bus.ram_data_i = d;
  endtask

  // Issues one SRAM write and checks its six cycles: IDLE, SETUP, PULSE x2, HOLD, DONE.
  // Returns at the falling edge of the DONE cycle with the request still held.
  task automatic sram_write(input logic [31:0] a, input logic [31:0] d);
    logic [51:0] exp_wr;
    drive_req(1'b1, a, d);
    exp_q.push_back({a[21:2], d});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("wr_stall_c%0d", c), 64'(ram_bus.stallreq_o), 64'(c <= 5));
      check($sformatf("wr_we_n_c%0d", c), 64'(sram_we_n), 64'(!(c == 3 || c == 4)));
      check($sformatf("wr_dq_oe_c%0d", c), 64'(sram_dq_oe), 64'(c >= 2 && c <= 5));
      check($sformatf("wr_oe_excl_c%0d", c), 64'(sram_dq_oe & ~sram_oe_n), 64'(0));
      check($sformatf("wr_rdata_c%0d", c), 64'(ram_bus.ram_data_o), 64'(0));
      if (c == 3) begin
        check("wr_queue_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          exp_wr = exp_q.pop_front();
          check("wr_addr_data", 64'({sram_addr, sram_dq_o}), 64'(exp_wr));
        end
        check("wr_ce_n", 64'(sram_ce_n), 64'(0));
      end
      if (c == 6) check("wr_done_state", 64'(state), 64'(DSC_DONE));
    end
  endtask

  initial begin
    rst                = 1'b1;
    ram_bus.ram_ce_i   = 1'b0;
    ram_bus.ram_we_i   = 1'b0;
    ram_bus.ram_addr_i = '0;
    ram_bus.ram_data_i = '0;
    sram_dq_i          = 32'hDEAD_BEEF;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_led", 64'(led), 64'(0));
    check("rst_we_n", 64'(sram_we_n), 64'(1));
    check("rst_ce_n", 64'(sram_ce_n), 64'(1));
    check("rst_oe_n", 64'(sram_oe_n), 64'(1));
    check("rst_dq_oe", 64'(sram_dq_oe), 64'(0));
    check("rst_stall", 64'(ram_bus.stallreq_o), 64'(0));
    check("rst_state", 64'(state), 64'(DSC_IDLE));
    check("idle_rdata", 64'(ram_bus.ram_data_o), 64'(0));

    // Plain read
    drive_req(1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    check("rd_addr", 64'(sram_addr), 64'(4));
    check("rd_oe_n", 64'(sram_oe_n), 64'(0));
    check("rd_ce_n", 64'(sram_ce_n), 64'(0));
    check("rd_we_n", 64'(sram_we_n), 64'(1));
    check("rd_data", 64'(ram_bus.ram_data_o), 64'h0000_0000_DEAD_BEEF);
    check("rd_stall", 64'(ram_bus.stallreq_o), 64'(0));

    // Aliased read: bits above ADDR_W+1 are dropped
    drive_req(1'b0, 32'h0040_0010, 32'h0);
    sram_dq_i = 32'h0BAD_F00D;
    @(negedge clk);
    check("alias_addr", 64'(sram_addr), 64'(4));
    check("alias_data", 64'(ram_bus.ram_data_o), 64'h0000_0000_0BAD_F00D);

    // Idle bus
    drive_idle();
    @(negedge clk);
    check("noce_ce_n", 64'(sram_ce_n), 64'(1));
    check("noce_oe_n", 64'(sram_oe_n), 64'(1));
    check("noce_rdata", 64'(ram_bus.ram_data_o), 64'(0));

    // LED write then read back
    drive_req(1'b1, 32'h1FFF_FFFC, 32'h0000_A5A5);
    @(negedge clk);
    check("led_wr_stall", 64'(ram_bus.stallreq_o), 64'(0));
    check("led_wr_ce_n", 64'(sram_ce_n), 64'(1));
    check("led_wr_we_n", 64'(sram_we_n), 64'(1));
    drive_req(1'b0, 32'h1FFF_FFFC, 32'h0);
    @(negedge clk);
    check("led_val", 64'(led), 64'h0000_0000_0000_A5A5);
    check("led_rd", 64'(ram_bus.ram_data_o), 64'h0000_0000_0000_A5A5);
    check("led_rd_oe_n", 64'(sram_oe_n), 64'(1));
    check("led_rd_stall", 64'(ram_bus.stallreq_o), 64'(0));

    // LED write at an unaligned byte address keeps only the low half-word
    drive_req(1'b1, 32'h1FFF_FFFE, 32'hFFFF_1234);
    drive_idle();
    @(negedge clk);
    check("led_unaligned", 64'(led), 64'h0000_0000_0000_1234);

    // Single SRAM write, then the CPU advances
    sram_write(32'h0000_0020, 32'h1234_5678);
    drive_idle();
    @(negedge clk);
    check("post_wr_stall", 64'(ram_bus.stallreq_o), 64'(0));
    check("post_wr_state", 64'(state), 64'(DSC_IDLE));
    check("post_wr_led", 64'(led), 64'h0000_0000_0000_1234);

    // Back-to-back writes with one DONE cycle between the stall windows
    sram_write(32'h0000_0100, 32'hCAFE_0001);
    sram_write(32'h0040_0104, 32'hCAFE_0002);
    drive_idle();
    @(negedge clk);
    check("b2b_stall_end", 64'(ram_bus.stallreq_o), 64'(0));
    check("b2b_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset during PULSE aborts the write at once
    drive_req(1'b1, 32'h0000_0030, 32'h5555_AAAA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_in_pulse", 64'(state), 64'(DSC_PULSE));
    check("abort_pulse_we_n", 64'(sram_we_n), 64'(0));
    rst              = 1'b1;
    ram_bus.ram_ce_i = 1'b0;
    ram_bus.ram_we_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_we_n", 64'(sram_we_n), 64'(1));
    check("abort_dq_oe", 64'(sram_dq_oe), 64'(0));
    check("abort_stall", 64'(ram_bus.stallreq_o), 64'(0));
    check("abort_state", 64'(state), 64'(DSC_IDLE));
    check("abort_led", 64'(led), 64'(0));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
